// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the operand sequencer: FSM state encoding and default widths.
package operand_sequencer_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned CountWidth   = 8;

  typedef enum logic [1:0] {
    StWaitA   = 2'd0,
    StWaitB   = 2'd1,
    StCompute = 2'd2,
    StHold    = 2'd3
  } state_e;

endpackage

// File: rtl/operand_sequencer.sv
// Loads A, then B/carry-in, from a shared bus, drives them to an external adder and
// offers the registered {cout, sum} on a valid/ready handshake, optionally chaining the sum.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  cin_in,
  input  logic                  load,
  input  logic                  chain,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_s,
  input  logic                  add_cout,
  output logic [WIDTH:0]        result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic [CountWidth-1:0] op_count
);

  state_e state_q, state_d;

  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic                  cin_q, cin_d;
  logic [WIDTH:0]        result_q, result_d;
  logic                  valid_q, valid_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  handshake;

  assign handshake = (state_q == StHold) && result_ready;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StWaitA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; load is ignored while COMPUTE/HOLD are in progress.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitA:   if (load) state_d = StWaitB;
      StWaitB:   if (load) state_d = StCompute;
      StCompute: state_d = StHold;
      StHold: begin
        if (result_ready) state_d = chain ? StWaitB : StWaitA;
      end
      default:   state_d = StWaitA;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == StCompute) || (state_q == StHold);
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    result_d = result_q;
    valid_d  = valid_q;
    unique case (state_q)
      StWaitA: begin
        if (load) a_d = data_in;
      end
      StWaitB: begin
        if (load) begin
          b_d   = data_in;
          cin_d = cin_in;
        end
      end
      StCompute: begin
        result_d = {add_cout, add_s};
        valid_d  = 1'b1;
      end
      StHold: begin
        if (result_ready) begin
          valid_d = 1'b0;
          // Chained step reuses the sum only; the carry bit is dropped.
          if (chain) a_d = result_q[WIDTH-1:0];
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Completed-handshake counter, wraps naturally at 2**CountWidth.
  always_comb begin
    count_d = count_q;
    if (handshake) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign add_a        = a_q;
  assign add_b        = b_q;
  assign add_cin      = cin_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign op_count     = count_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer with a behavioural adder and transaction model.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] data_in = '0;
  logic       cin_in = 1'b0;
  logic       load = 1'b0;
  logic       chain = 1'b0;
  logic [3:0] add_a, add_b, add_s;
  logic       add_cin, add_cout;
  logic [4:0] result;
  logic       result_valid;
  logic       result_ready = 1'b0;
  logic       busy;
  logic [7:0] op_count;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: current A operand and completed handshakes.
  int model_a = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  operand_sequencer #(.WIDTH(4)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_in      (data_in),
    .cin_in       (cin_in),
    .load         (load),
    .chain        (chain),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_s        (add_s),
    .add_cout     (add_cout),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .op_count     (op_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [3:0] d, input logic c);
    data_in = d;
    cin_in  = c;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  // One full transaction from the WAIT_A (load_a=1) or WAIT_B (load_a=0) state.
  task automatic run_txn(input logic load_a, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic ch, input int stall, input string tag);
    int exp_sum;
    logic [4:0] held;
    if (load_a) begin
      pulse_load(a, 1'b0);
      model_a = int'(a);
      n_checks++;
      if (add_a !== 4'(model_a) || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s A load: add_a=%0d busy=%b, want add_a=%0d busy=0", tag, add_a, busy,
                 model_a);
      end
    end
    pulse_load(b, c);
    exp_sum = model_a + int'(b) + int'(c);
    n_checks++;
    if (busy !== 1'b1 || result_valid !== 1'b0 || add_b !== b || add_cin !== c) begin
      n_fail++;
      $display("FAIL %s compute: busy=%b valid=%b add_b=%0d cin=%b, want 1 0 %0d %b", tag, busy,
               result_valid, add_b, add_cin, b, c);
    end
    step();
    n_checks++;
    if (result_valid !== 1'b1 || result !== 5'(exp_sum)) begin
      n_fail++;
      $display("FAIL %s result: valid=%b result=%0d, want valid=1 result=%0d", tag,
               result_valid, result, exp_sum);
    end
    held = 5'(exp_sum);
    for (int i = 0; i < stall; i++) begin
      result_ready = 1'b0;
      load    = 1'($urandom_range(0, 1));
      data_in = 4'($urandom);
      cin_in  = 1'($urandom);
      chain   = 1'($urandom);
      step();
      n_checks++;
      if (result_valid !== 1'b1 || result !== held || add_a !== 4'(model_a) || add_b !== b ||
          busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s hold[%0d]: valid=%b result=%0d a=%0d b=%0d busy=%b, want 1 %0d %0d %0d 1",
                 tag, i, result_valid, result, add_a, add_b, busy, held, model_a, b);
      end
    end
    load = 1'b0;
    result_ready = 1'b1;
    chain = ch;
    step();
    result_ready = 1'b0;
    chain = 1'b0;
    model_cnt = (model_cnt + 1) % 256;
    if (ch) model_a = exp_sum % 16;
    n_checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'(model_cnt) ||
        add_a !== 4'(model_a)) begin
      n_fail++;
      $display("FAIL %s handshake: valid=%b busy=%b count=%0d a=%0d, want 0 0 %0d %0d", tag,
               result_valid, busy, op_count, add_a, model_cnt, model_a);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    load = 1'b0;
    result_ready = 1'b0;
    chain = 1'b0;
    step();
    step();
    resetn = 1'b1;
    model_a = 0;
    model_cnt = 0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0 || result !== 5'd0 ||
        result_valid !== 1'b0 || op_count !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: a=%0d b=%0d cin=%b res=%0d valid=%b cnt=%0d busy=%b, want all 0",
               add_a, add_b, add_cin, result, result_valid, op_count, busy);
    end
  endtask

  task automatic test_basic();
    run_txn(1'b1, 4'd3, 4'd4, 1'b0, 1'b0, 0, "basic");
    // Back in WAIT_A: a single load must not start a computation.
    pulse_load(4'd1, 1'b0);
    step();
    n_checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || add_a !== 4'd1) begin
      n_fail++;
      $display("FAIL basic wait_a: busy=%b valid=%b a=%0d, want 0 0 1", busy, result_valid,
               add_a);
    end
    model_a = 1;
    run_txn(1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 0, "basic_b_only");
  endtask

  task automatic test_carry();
    run_txn(1'b1, 4'd15, 4'd15, 1'b1, 1'b0, 0, "carry_31");
    run_txn(1'b1, 4'd8, 4'd8, 1'b0, 1'b0, 1, "carry_16");
  endtask

  task automatic test_backpressure();
    run_txn(1'b1, 4'd9, 4'd6, 1'b1, 1'b0, 10, "backpressure");
  endtask

  task automatic test_chain();
    run_txn(1'b1, 4'd2, 4'd5, 1'b0, 1'b1, 0, "chain_7");
    run_txn(1'b0, 4'd0, 4'd9, 1'b0, 1'b1, 2, "chain_16");
    run_txn(1'b0, 4'd0, 4'd4, 1'b1, 1'b0, 0, "chain_end");
  endtask

  task automatic test_random();
    logic ch_prev = 1'b0;
    for (int t = 0; t < 40; t++) begin
      logic ch;
      int idle;
      ch = 1'($urandom);
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        data_in = 4'($urandom);
        result_ready = 1'($urandom);
        step();
        result_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || add_a !== 4'(model_a)) begin
          n_fail++;
          $display("FAIL random idle[%0d]: busy=%b a=%0d, want 0 %0d", t, busy, add_a, model_a);
        end
      end
      run_txn(!ch_prev, 4'($urandom), 4'($urandom), 1'($urandom), ch, $urandom_range(0, 3),
              "random");
      ch_prev = ch;
    end
    if (ch_prev) run_txn(1'b0, 4'd0, 4'($urandom), 1'b0, 1'b0, 0, "random_close");
  endtask

  task automatic test_reset_midop();
    pulse_load(4'd6, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (add_a !== 4'd0 || add_b !== 4'd0 || add_cin !== 1'b0 || result !== 5'd0 ||
        result_valid !== 1'b0 || op_count !== 8'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop async: a=%0d b=%0d cnt=%0d valid=%b busy=%b, want all 0",
               add_a, add_b, op_count, result_valid, busy);
    end
    step();
    resetn = 1'b1;
    model_a = 0;
    model_cnt = 0;
    step();
    pulse_load(4'd9, 1'b1);
    step();
    n_checks++;
    if (add_a !== 4'd9 || add_b !== 4'd0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop reload: a=%0d b=%0d busy=%b valid=%b, want 9 0 0 0", add_a,
               add_b, busy, result_valid);
    end
    model_a = 9;
    run_txn(1'b0, 4'd0, 4'd1, 1'b0, 1'b0, 0, "reset_midop_b");
  endtask

  task automatic test_wrap();
    do_reset();
    pulse_load(4'($urandom), 1'b0);
    model_a = int'(add_a);
    for (int i = 0; i < 256; i++) begin
      run_txn(1'b0, 4'd0, 4'($urandom), 1'($urandom), 1'b1, 0, "wrap");
      if (i == 254) begin
        n_checks++;
        if (op_count !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_255: op_count=%0d, want 255", op_count);
        end
      end
    end
    n_checks++;
    if (op_count !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_0: op_count=%0d, want 0", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_chain();
    test_random();
    test_reset_midop();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
